// File: rtl/adxl362_spi_responder.sv
// ADXL362 SPI register-interface responder (SPI mode 0, read 0x0B / write 0x0A).
// Serves a 64-byte register map: ID, sample data, status and writable config.
module adxl362_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  REVID       = 8'h01
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        CS,
  output logic        MISO,
  input  logic        sampleValid,
  input  logic [11:0] sampleX,
  input  logic [11:0] sampleY,
  input  logic [11:0] sampleZ,
  output logic        busy,
  output logic        wrStrobe,
  output logic [5:0]  wrAddr,
  output logic [7:0]  wrData,
  output logic [7:0]  powerCtl,
  output logic        measuring
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic sclk_d, cs_d;
  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [2:0] cnt;
  logic [6:0] sh;
  logic [7:0] rx_byte;
  logic [7:0] tx;
  logic [5:0] addr;
  logic       rd_cmd;
  logic       data_hit;
  logic       byte_done;

  logic [5:0] fetch_addr;
  logic [7:0] rd_data;
  logic       wr_commit, soft_commit, copy, data_addr;

  logic [7:0]  rw_regs [0:15];
  logic [11:0] sx, sy, sz;
  logic [11:0] dx, dy, dz;
  logic        pend;
  logic        data_ready;

  // Synchronisers and edge-detect flops; left unreset so a reset with CS held
  // low does not fabricate a CS fall.
  always_ff @(posedge Clock) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
    sclk_d    <= sclk_sync[SYNC_STAGES-1];
    cs_d      <= cs_sync[SYNC_STAGES-1];
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign busy      = ~cs_s;

  assign rx_byte   = {sh, mosi_s};
  assign byte_done = sclk_rise && (cnt == 3'd7);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_next = ST_CMD;
        ST_CMD:  if (byte_done)
                   state_next = (rx_byte == 8'h0B || rx_byte == 8'h0A) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: if (byte_done) state_next = rd_cmd ? ST_RDATA : ST_WDATA;
        default: ;
      endcase
    end
  end

  // Register read mux and write/sample control decode
  always_comb begin
    fetch_addr = (state == ST_ADDR) ? rx_byte[5:0] : addr + 6'd1;
    rd_data    = '0;
    case (fetch_addr)
      6'h00: rd_data = 8'hAD;
      6'h01: rd_data = 8'h1D;
      6'h02: rd_data = 8'hF2;
      6'h03: rd_data = REVID;
      6'h08: rd_data = dx[11:4];
      6'h09: rd_data = dy[11:4];
      6'h0A: rd_data = dz[11:4];
      6'h0B: rd_data = {7'b0, data_ready};
      6'h0E: rd_data = dx[7:0];
      6'h0F: rd_data = {{4{dx[11]}}, dx[11:8]};
      6'h10: rd_data = dy[7:0];
      6'h11: rd_data = {{4{dy[11]}}, dy[11:8]};
      6'h12: rd_data = dz[7:0];
      6'h13: rd_data = {{4{dz[11]}}, dz[11:8]};
      default:
        if (fetch_addr >= 6'h20 && fetch_addr <= 6'h2E) rd_data = rw_regs[fetch_addr[3:0]];
    endcase
    wr_commit   = (state == ST_WDATA) && byte_done && !cs_rise &&
                  (addr >= 6'h20) && (addr <= 6'h2E);
    soft_commit = (state == ST_WDATA) && byte_done && !cs_rise &&
                  (addr == 6'h1F) && (rx_byte == 8'h52);
    copy        = cs_s && pend;
    data_addr   = ((addr >= 6'h08) && (addr <= 6'h0A)) ||
                  ((addr >= 6'h0E) && (addr <= 6'h13));
  end

  // SPI shift, address, TX and write-port datapath
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt      <= '0;
      sh       <= '0;
      tx       <= '0;
      addr     <= '0;
      rd_cmd   <= 1'b0;
      data_hit <= 1'b0;
      MISO     <= 1'b0;
      wrStrobe <= 1'b0;
      wrAddr   <= '0;
      wrData   <= '0;
    end else begin
      wrStrobe <= 1'b0;
      if (cs_rise || cs_fall) begin
        cnt  <= '0;
        MISO <= 1'b0;
        if (cs_fall) data_hit <= 1'b0;
      end else begin
        if (state != ST_RDATA) MISO <= 1'b0;
        if (sclk_rise && (state != ST_IDLE) && (state != ST_IGNORE)) begin
          sh  <= rx_byte[6:0];
          cnt <= cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            ST_CMD:  rd_cmd <= (rx_byte == 8'h0B);
            ST_ADDR: begin
              addr <= rx_byte[5:0];
              if (rd_cmd) tx <= rd_data;
            end
            ST_RDATA: begin
              addr <= addr + 6'd1;
              tx   <= rd_data;
            end
            ST_WDATA: begin
              addr <= addr + 6'd1;
              if (wr_commit) begin
                wrStrobe <= 1'b1;
                wrAddr   <= addr;
                wrData   <= rx_byte;
              end
            end
            default: ;
          endcase
        end
        // addr always names the byte held in tx, so the first fall of a byte
        // is where it is actually returned to the initiator.
        if ((state == ST_RDATA) && sclk_fall) begin
          MISO <= tx[7];
          tx   <= {tx[6:0], 1'b0};
          if ((cnt == 3'd0) && data_addr) data_hit <= 1'b1;
        end
      end
    end
  end

  // Register file, sample shadow/data registers and DATA_READY
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 16; i++) rw_regs[i] <= '0;
      sx         <= '0;
      sy         <= '0;
      sz         <= '0;
      dx         <= '0;
      dy         <= '0;
      dz         <= '0;
      pend       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      if (sampleValid) begin
        sx   <= sampleX;
        sy   <= sampleY;
        sz   <= sampleZ;
        pend <= 1'b1;
      end else if (copy) begin
        pend <= 1'b0;
      end
      if (copy) begin
        dx <= sx;
        dy <= sy;
        dz <= sz;
      end
      if (wr_commit) rw_regs[addr[3:0]] <= rx_byte;
      if (soft_commit)
        for (int unsigned i = 0; i < 16; i++) rw_regs[i] <= '0;
      if (copy)
        data_ready <= 1'b1;
      else if (soft_commit || (cs_rise && data_hit))
        data_ready <= 1'b0;
    end
  end

  assign powerCtl  = rw_regs[13];
  assign measuring = (powerCtl[1:0] == 2'b10);

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed self-checking bench for adxl362_spi_responder.
module tb_adxl362_spi_responder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        SCLK;
  logic        MOSI;
  logic        CS;
  logic        MISO;
  logic        sampleValid;
  logic [11:0] sampleX, sampleY, sampleZ;
  logic        busy;
  logic        wrStrobe;
  logic [5:0]  wrAddr;
  logic [7:0]  wrData;
  logic [7:0]  powerCtl;
  logic        measuring;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  logic [5:0] wr_last_addr = '0;
  logic [7:0] wr_last_data = '0;
  logic [7:0] r [0:7];

  adxl362_spi_responder #(
    .SYNC_STAGES(2),
    .REVID(8'h01)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .CS(CS),
    .MISO(MISO),
    .sampleValid(sampleValid),
    .sampleX(sampleX),
    .sampleY(sampleY),
    .sampleZ(sampleZ),
    .busy(busy),
    .wrStrobe(wrStrobe),
    .wrAddr(wrAddr),
    .wrData(wrData),
    .powerCtl(powerCtl),
    .measuring(measuring)
  );

  always #5 Clock = ~Clock;

  // Record committed writes
  always @(negedge Clock) begin
    if (wrStrobe === 1'b1) begin
      wr_count     <= wr_count + 1;
      wr_last_addr <= wrAddr;
      wr_last_data <= wrData;
    end
  end

  // Global time limit
  initial begin
    #5000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic half();
    repeat (8) @(negedge Clock);
  endtask

  task automatic cs_low();
    CS = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    CS = 1'b1;
    repeat (12) @(negedge Clock);
  endtask

  task automatic xfer(input logic [7:0] b, output logic [7:0] rb);
    for (int i = 7; i >= 0; i--) begin
      MOSI = b[i];
      half();
      rb[i] = MISO;
      SCLK = 1'b1;
      half();
      SCLK = 1'b0;
    end
  endtask

  task automatic xfer_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = b[i];
      half();
      SCLK = 1'b1;
      half();
      SCLK = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [5:0] a, input int n);
    logic [7:0] d;
    cs_low();
    xfer(8'h0B, d);
    xfer({2'b00, a}, d);
    for (int k = 0; k < n; k++) xfer(8'h00, r[k]);
    cs_high();
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [7:0] v);
    logic [7:0] d;
    cs_low();
    xfer(8'h0A, d);
    xfer({2'b00, a}, d);
    xfer(v, d);
    cs_high();
  endtask

  task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    sampleX = x;
    sampleY = y;
    sampleZ = z;
    sampleValid = 1'b1;
    @(negedge Clock);
    sampleValid = 1'b0;
    repeat (4) @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (10) @(negedge Clock);
    checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", MISO); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wrStrobe !== 1'b0) begin failures++; $display("FAIL reset_wrstrobe got=%b exp=0", wrStrobe); end
    checks++; if (wrAddr !== 6'h00) begin failures++; $display("FAIL reset_wraddr got=%h exp=00", wrAddr); end
    checks++; if (wrData !== 8'h00) begin failures++; $display("FAIL reset_wrdata got=%h exp=00", wrData); end
    checks++; if (powerCtl !== 8'h00) begin failures++; $display("FAIL reset_powerctl got=%h exp=00", powerCtl); end
    checks++; if (measuring !== 1'b0) begin failures++; $display("FAIL reset_measuring got=%b exp=0", measuring); end
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
  endtask

  task automatic test_id_read();
    logic [7:0] d;
    logic [7:0] e [0:3];
    e = '{8'hAD, 8'h1D, 8'hF2, 8'h01};
    cs_low();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL id_busy_start got=%b exp=1", busy); end
    xfer(8'h0B, d);
    xfer(8'h00, d);
    for (int k = 0; k < 4; k++) xfer(8'h00, r[k]);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL id_busy_end got=%b exp=1", busy); end
    cs_high();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL id_busy_after got=%b exp=0", busy); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r[k] !== e[k]) begin failures++; $display("FAIL id_byte%0d got=%h exp=%h", k, r[k], e[k]); end
    end
  endtask

  task automatic test_write();
    int c0;
    c0 = wr_count;
    write_reg(6'h2D, 8'h02);
    checks++; if (wr_count !== c0 + 1) begin failures++; $display("FAIL wr_strobes got=%0d exp=%0d", wr_count - c0, 1); end
    checks++; if (wr_last_addr !== 6'h2D) begin failures++; $display("FAIL wr_addr got=%h exp=2d", wr_last_addr); end
    checks++; if (wr_last_data !== 8'h02) begin failures++; $display("FAIL wr_data got=%h exp=02", wr_last_data); end
    checks++; if (powerCtl !== 8'h02) begin failures++; $display("FAIL wr_powerctl got=%h exp=02", powerCtl); end
    checks++; if (measuring !== 1'b1) begin failures++; $display("FAIL wr_measuring got=%b exp=1", measuring); end
    read_burst(6'h2D, 1);
    checks++; if (r[0] !== 8'h02) begin failures++; $display("FAIL wr_readback got=%h exp=02", r[0]); end
  endtask

  task automatic test_samples();
    logic [7:0] e [0:5];
    e = '{8'h23, 8'h01, 8'h85, 8'hFF, 8'hFF, 8'h07};
    pulse_sample(12'h123, 12'hF85, 12'h7FF);
    read_burst(6'h0B, 1);
    checks++; if (r[0] !== 8'h01) begin failures++; $display("FAIL status_ready got=%h exp=01", r[0]); end
    read_burst(6'h0E, 6);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (r[k] !== e[k]) begin failures++; $display("FAIL sample_byte%0d got=%h exp=%h", k, r[k], e[k]); end
    end
    read_burst(6'h0B, 1);
    checks++; if (r[0] !== 8'h00) begin failures++; $display("FAIL status_cleared got=%h exp=00", r[0]); end
  endtask

  task automatic test_coherency();
    logic [7:0] d;
    cs_low();
    xfer(8'h0B, d);
    xfer(8'h0E, d);
    pulse_sample(12'h010, 12'hF85, 12'h7FF);
    xfer(8'h00, r[0]);
    xfer(8'h00, r[1]);
    cs_high();
    checks++; if (r[0] !== 8'h23) begin failures++; $display("FAIL coh_xlo got=%h exp=23", r[0]); end
    checks++; if (r[1] !== 8'h01) begin failures++; $display("FAIL coh_xhi got=%h exp=01", r[1]); end
    read_burst(6'h0B, 1);
    checks++; if (r[0] !== 8'h01) begin failures++; $display("FAIL coh_status_setwins got=%h exp=01", r[0]); end
    read_burst(6'h08, 1);
    checks++; if (r[0] !== 8'h01) begin failures++; $display("FAIL coh_x8 got=%h exp=01", r[0]); end
    read_burst(6'h0B, 1);
    checks++; if (r[0] !== 8'h00) begin failures++; $display("FAIL coh_status_clr got=%h exp=00", r[0]); end
  endtask

  task automatic test_wrap_illegal();
    int c0;
    logic [7:0] acc;
    read_burst(6'h3F, 2);
    checks++; if (r[0] !== 8'h00) begin failures++; $display("FAIL wrap_3f got=%h exp=00", r[0]); end
    checks++; if (r[1] !== 8'hAD) begin failures++; $display("FAIL wrap_00 got=%h exp=ad", r[1]); end
    c0 = wr_count;
    write_reg(6'h05, 8'h77);
    checks++; if (wr_count !== c0) begin failures++; $display("FAIL illegal_strobe got=%0d exp=0", wr_count - c0); end
    read_burst(6'h05, 1);
    checks++; if (r[0] !== 8'h00) begin failures++; $display("FAIL illegal_read got=%h exp=00", r[0]); end
    cs_low();
    xfer(8'h0D, r[0]);
    xfer(8'h0B, r[1]);
    xfer(8'h00, r[2]);
    xfer(8'h00, r[3]);
    cs_high();
    acc = r[0] | r[1] | r[2] | r[3];
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL ignore_miso got=%h exp=00", acc); end
  endtask

  task automatic test_abort_softreset();
    int c0;
    logic [7:0] d;
    c0 = wr_count;
    cs_low();
    xfer(8'h0A, d);
    xfer(8'h20, d);
    xfer(8'hA5, d);
    xfer(8'h5A, d);
    cs_high();
    checks++; if (wr_count !== c0 + 2) begin failures++; $display("FAIL burst_strobes got=%0d exp=2", wr_count - c0); end
    checks++; if (wr_last_addr !== 6'h21) begin failures++; $display("FAIL burst_addr got=%h exp=21", wr_last_addr); end
    read_burst(6'h20, 2);
    checks++; if (r[0] !== 8'hA5) begin failures++; $display("FAIL burst_rd20 got=%h exp=a5", r[0]); end
    checks++; if (r[1] !== 8'h5A) begin failures++; $display("FAIL burst_rd21 got=%h exp=5a", r[1]); end
    c0 = wr_count;
    cs_low();
    xfer(8'h0A, d);
    xfer(8'h2D, d);
    xfer_bits(8'h55, 5);
    cs_high();
    checks++; if (wr_count !== c0) begin failures++; $display("FAIL abort_strobe got=%0d exp=0", wr_count - c0); end
    checks++; if (powerCtl !== 8'h02) begin failures++; $display("FAIL abort_powerctl got=%h exp=02", powerCtl); end
    write_reg(6'h1F, 8'h52);
    checks++; if (powerCtl !== 8'h00) begin failures++; $display("FAIL soft_powerctl got=%h exp=00", powerCtl); end
    checks++; if (measuring !== 1'b0) begin failures++; $display("FAIL soft_measuring got=%b exp=0", measuring); end
    read_burst(6'h20, 2);
    checks++; if (r[0] !== 8'h00) begin failures++; $display("FAIL soft_rd20 got=%h exp=00", r[0]); end
    checks++; if (r[1] !== 8'h00) begin failures++; $display("FAIL soft_rd21 got=%h exp=00", r[1]); end
    read_burst(6'h0E, 1);
    checks++; if (r[0] !== 8'h10) begin failures++; $display("FAIL soft_data got=%h exp=10", r[0]); end
    read_burst(6'h00, 1);
    checks++; if (r[0] !== 8'hAD) begin failures++; $display("FAIL soft_id got=%h exp=ad", r[0]); end
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [7:0] d;
    c0 = wr_count;
    cs_low();
    xfer(8'h0A, d);
    xfer(8'h2D, d);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    xfer(8'h03, d);
    cs_high();
    checks++; if (wr_count !== c0) begin failures++; $display("FAIL rstmid_strobe got=%0d exp=0", wr_count - c0); end
    checks++; if (powerCtl !== 8'h00) begin failures++; $display("FAIL rstmid_powerctl got=%h exp=00", powerCtl); end
    read_burst(6'h00, 2);
    checks++; if (r[0] !== 8'hAD) begin failures++; $display("FAIL rstmid_id0 got=%h exp=ad", r[0]); end
    checks++; if (r[1] !== 8'h1D) begin failures++; $display("FAIL rstmid_id1 got=%h exp=1d", r[1]); end
  endtask

  initial begin
    Reset       = 1'b1;
    SCLK        = 1'b0;
    MOSI        = 1'b0;
    CS          = 1'b1;
    sampleValid = 1'b0;
    sampleX     = '0;
    sampleY     = '0;
    sampleZ     = '0;
    test_reset();
    test_id_read();
    test_write();
    test_samples();
    test_coherency();
    test_wrap_illegal();
    test_abort_softreset();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adxl362_spi_responder.md
Name: adxl362_spi_responder

Overview:
Behavioural-synthesisable model of the ADXL362 accelerometer's SPI register interface, acting as the responder to the PmodACL2 initiator. It decodes read (0x0B) and write (0x0A) commands in SPI mode 0 and serves a 64-byte register map: ID registers, sample data, status and writable configuration. Sample values come from bench or host logic on the sample port. It replaces the generic byte-echo slave in closed-loop simulation and on-board loopback demos.

Parameters:
SYNC_STAGES, 2, synchroniser depth on SCLK/MOSI/CS (min 2).
REVID, 8'h01, value returned at address 0x03.

Ports:
Clock  input  1  system clock; all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
SCLK  input  1  SPI clock from initiator, asynchronous to Clock.
MOSI  input  1  SPI data in.
CS  input  1  chip select, active low.
MISO  output  1  SPI data out, MSB first; plain driven output, no tri-state.
sampleValid  input  1  one-cycle strobe: latch sampleX/Y/Z.
sampleX  input  12  signed X sample.
sampleY  input  12  signed Y sample.
sampleZ  input  12  signed Z sample.
busy  output  1  high while synchronised CS is low.
wrStrobe  output  1  one-cycle pulse per committed register write.
wrAddr  output  6  address of the committed write.
wrData  output  8  data of the committed write.
powerCtl  output  8  current register 0x2D.
measuring  output  1  powerCtl[1:0]==2'b10.

Behaviour:
- Reset: MISO=0, busy=0, wrStrobe=0, wrAddr=0, wrData=0, powerCtl=0, measuring=0. State=IDLE. Writable registers=0, shadow and data samples=0, DATA_READY=0.
- Inputs pass through SYNC_STAGES flops plus one edge-detect flop. Rise/fall/CS-fall/CS-rise are one-cycle events. Required: SCLK high and low each >= SYNC_STAGES+2 Clock cycles.
- Register map: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, 0x03=REVID.
- 0x08/0x09/0x0A = X/Y/Z[11:4].
- 0x0B STATUS: bit0=DATA_READY; other bits 0.
- 0x0E/0x0F=X low byte / {4{X[11]},X[11:8]}; 0x10/0x11 Y; 0x12/0x13 Z.
- 0x20–0x2E are read/write. All other addresses read 0x00; writes to them are ignored, with no wrStrobe.
- Sampling: sampleValid loads shadow registers every time.
- Shadow copies into the data registers only while CS is high, including the cycle CS rises. If CS is low, the copy is deferred to the CS rise, so a burst always sees one coherent sample.
- DATA_READY sets when a new sample reaches the data registers. It clears at CS rise of any read transaction that returned a byte from 0x08–0x0A or 0x0E–0x13. If a set and a clear land in the same cycle, set wins.
- FSM: IDLE -> CMD on CS fall; bit counter=0, MISO=0.
- CMD: shift MOSI on each SCLK rise. After the 8th rise: 0x0B or 0x0A -> ADDR; any other value -> IGNORE.
- ADDR: 8 rises; address = low 6 bits. Read: on the 8th rise, fetch reg[addr] into the TX shifter. Write: go to WDATA.
- RDATA: drive TX bit7 on MISO at the first SCLK fall after the fetch, then shift on each later fall. On the 8th rise of each data byte, addr = addr+1 (0x3F wraps to 0x00) and the next byte is fetched.
- WDATA: on the 8th rise, commit to a writable address. wrStrobe pulses one cycle after that rise, with wrAddr/wrData valid. Then addr increments, with the same wrap.
- IGNORE: MISO=0 until CS rise.
- MISO=0 in IDLE, CMD, ADDR, IGNORE and WDATA.
- CS rise in any state -> IDLE the next cycle; the partial byte is discarded (no write, no increment); MISO=0.
- Writing 0x52 to 0x1F (SOFT_RESET) clears 0x20–0x2E and DATA_READY at the commit cycle. ID and data registers are unaffected.
- Reset mid-transaction: immediate IDLE. The remaining SCLK edges are ignored until a fresh CS fall.

Test Plan:
- Read burst CS low, 0x0B,0x00, then 4 dummy bytes -> MISO bytes 0xAD,0x1D,0xF2,REVID; busy high throughout.
- Write 0x0A,0x2D,0x02 -> one wrStrobe with wrAddr=0x2D, wrData=0x02; powerCtl=0x02, measuring=1. Then read 0x2D -> 0x02.
- sampleValid with X=0x123, Y=0xF85, Z=0x7FF; burst read 0x0E x6 -> 0x23,0x01,0x85,0xFF,0xFF,0x07. STATUS read beforehand =0x01; after the CS rise, STATUS =0x00.
- Coherency: sampleValid X=0x010 mid-burst at 0x0E -> that burst returns the old X. After the CS rise, 0x08 reads 0x01.
- Wrap and illegal writes: read from 0x3F x2 -> 0x00 then 0xAD. Write 0x0A,0x05,0x77 -> no wrStrobe. Command 0x0D -> MISO stays 0 for the whole transaction.
- Abort: CS rises after 5 bits of a write data byte -> no wrStrobe, register unchanged. SOFT_RESET 0x52 -> powerCtl=0x00.
